// File: rtl/wb_pkg.sv
// Shared Wibone definitions for the block-copy initiator.
//   - Cycle-type (CTI) and burst-type (BTE) encodings used on the bus.
//   - The copier's state encoding.
//   - beat_cti(): the cycle type to present for a given beat of a burst.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_GAP,
        ST_WR,
        ST_FIN
    } dma_state_e;

    // A one-word burst is a classic cycle; longer bursts are incrementing
    // with the final beat marked as end-of-burst.
    function automatic logic [2:0] beat_cti(input logic [4:0] beat, input logic [4:0] chunk);
        if (chunk == 5'd1) begin
            return CTI_CLASSIC;
        end else if (beat == chunk - 5'd1) begin
            return CTI_END;
        end else begin
            return CTI_INCR;
        end
    endfunction

endpackage

// File: rtl/wb_dma_buf.sv
// Burst staging buffer: DEPTH x 32 register file.
//   clk      - clock
//   wr_en    - write strobe
//   wr_idx   - write index
//   wr_data  - write data
//   rd_idx   - read index
//   rd_data  - read data (combinational from rd_idx)
module wb_dma_buf
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/wb_dma_copier.sv
// Wishbone block copier: moves len 32-bit words from src_adr to dst_adr in
// bursts of up to BURST words (read burst into buffer, idle cycle, write burst).
//   sys_clk, sys_rst          - clock, synchronous active-high reset
//   start, src_adr, dst_adr,
//   len                       - command strobe and operands (accepted when idle)
//   busy, done, error,
//   words_done                - status
//   wb_*                      - Wishbone initiator port
module wb_dma_copier
    import wb_pkg::*;
#(
    parameter int BURST = 4,
    parameter int LEN_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [29:0]      src_adr,
    input  logic [29:0]      dst_adr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic [29:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic [3:0]       wb_sel_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);

    localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int CW = $clog2(BURST) + 1;

    dma_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [29:0]      src_q, src_d;
    logic [29:0]      dst_q, dst_d;
    logic [29:0]      adr_q, adr_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [2:0]       cti_q, cti_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic [CW-1:0]    chunk_q, chunk_d;
    logic             to_wr_q, to_wr_d;

    logic             buf_we;
    logic [31:0]      buf_rd;
    logic             beat_ack;
    logic             beat_err;
    logic             last_beat;
    logic [CW-1:0]    new_chunk;

    wb_dma_buf #(
        .DEPTH (BURST),
        .IW    (IW)
    ) u_buf (
        .clk     (sys_clk),
        .wr_en   (buf_we),
        .wr_idx  (beat_q[IW-1:0]),
        .wr_data (wb_dat_i),
        .rd_idx  (beat_q[IW-1:0]),
        .rd_data (buf_rd)
    );

    // err wins over a simultaneous ack
    assign beat_err  = cyc_q & wb_err_i;
    assign beat_ack  = cyc_q & wb_ack_i & ~wb_err_i;
    assign last_beat = (beat_q == chunk_q - CW'(1));

    always_comb begin
        if (remaining_q >= LEN_W'(BURST)) begin
            new_chunk = CW'(BURST);
        end else begin
            new_chunk = remaining_q[CW-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        words_d     = words_q;
        remaining_d = remaining_q;
        src_d       = src_q;
        dst_d       = dst_q;
        adr_d       = adr_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        cti_d       = cti_q;
        beat_d      = beat_q;
        chunk_d     = chunk_q;
        to_wr_d     = to_wr_q;
        buf_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d       = src_adr;
                    dst_d       = dst_adr;
                    remaining_d = len;
                    error_d     = 1'b0;
                    words_d     = '0;
                    busy_d      = 1'b1;
                    to_wr_d     = 1'b0;
                    // The idle cycle doubles as the launch cycle: it decides
                    // between a read burst and an immediate finish (len=0).
                    state_d     = ST_GAP;
                end
            end

            ST_GAP: begin
                if (to_wr_q) begin
                    state_d = ST_WR;
                    adr_d   = dst_q;
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    beat_d  = '0;
                    cti_d   = beat_cti(5'd0, 5'(chunk_q));
                end else if (remaining_q != '0) begin
                    state_d = ST_RD;
                    chunk_d = new_chunk;
                    adr_d   = src_q;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    beat_d  = '0;
                    cti_d   = beat_cti(5'd0, 5'(new_chunk));
                end else begin
                    state_d = ST_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            ST_RD, ST_WR: begin
                if (beat_err) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    cti_d   = CTI_CLASSIC;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else if (beat_ack) begin
                    if (state_q == ST_RD) begin
                        buf_we = 1'b1;
                    end else begin
                        words_d = words_q + LEN_W'(1);
                        dst_d   = dst_q + 30'd1;
                    end
                    if (last_beat) begin
                        cyc_d   = 1'b0;
                        we_d    = 1'b0;
                        cti_d   = CTI_CLASSIC;
                        state_d = ST_GAP;
                        if (state_q == ST_RD) begin
                            to_wr_d = 1'b1;
                        end else begin
                            to_wr_d     = 1'b0;
                            remaining_d = remaining_q - LEN_W'(chunk_q);
                            src_d       = src_q + 30'(chunk_q);
                        end
                    end else begin
                        adr_d  = adr_q + 30'd1;
                        beat_d = beat_q + CW'(1);
                        cti_d  = beat_cti(5'(beat_q + CW'(1)), 5'(chunk_q));
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
            remaining_q <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            adr_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            cti_q       <= CTI_CLASSIC;
            beat_q      <= '0;
            chunk_q     <= '0;
            to_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_q     <= words_d;
            remaining_q <= remaining_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            adr_q       <= adr_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            cti_q       <= cti_d;
            beat_q      <= beat_d;
            chunk_q     <= chunk_d;
            to_wr_q     <= to_wr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words_done = words_q;
    assign wb_adr_o   = adr_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = we_q;
    assign wb_cti_o   = cti_q;
    assign wb_bte_o   = BTE_LINEAR;
    assign wb_sel_o   = cyc_q ? 4'b1111 : 4'b0000;
    // Buffer contents are undefined outside a write burst, so keep the bus quiet.
    assign wb_dat_o   = we_q ? buf_rd : 32'd0;

endmodule

// File: tb/tb_wb_dma_copier.sv
// Directed bench for wb_dma_copier with a Wishbone memory responder.
module tb_wb_dma_copier;

    localparam int BURST = 4;
    localparam int LEN_W = 16;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             start = 1'b0;
    logic [29:0]      src_adr = '0;
    logic [29:0]      dst_adr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, error;
    logic [LEN_W-1:0] words_done;
    logic [29:0]      wb_adr_o;
    logic [31:0]      wb_dat_o, wb_dat_i;
    logic [3:0]       wb_sel_o;
    logic             wb_cyc_o, wb_stb_o, wb_we_o;
    logic [2:0]       wb_cti_o;
    logic [1:0]       wb_bte_o;
    logic             wb_ack_i, wb_err_i;

    always #5 sys_clk = ~sys_clk;

    wb_dma_copier #(.BURST(BURST), .LEN_W(LEN_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
        .src_adr(src_adr), .dst_adr(dst_adr), .len(len),
        .busy(busy), .done(done), .error(error), .words_done(words_done),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_val(input logic [9:0] a);
        return 32'h5A00_0000 | (32'(a) * 32'h0001_0003);
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] mem [1024];
    bit          wr_flag [1024];
    int          ack_mode = 0;   // 0: always ack, 1: random 50%, 2: never
    bit          err_en = 1'b0;
    logic [29:0] err_adr = '0;
    logic        ack_ok;

    assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_ok;
    assign wb_err_i = wb_cyc_o & wb_stb_o & wb_we_o & err_en & (wb_adr_o == err_adr);
    always_comb wb_dat_i = wr_flag[wb_adr_o[9:0]] ? mem[wb_adr_o[9:0]] : init_val(wb_adr_o[9:0]);

    always @(posedge sys_clk) begin
        ack_ok <= (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i && !wb_err_i) begin
            mem[wb_adr_o[9:0]]     <= wb_dat_o;
            wr_flag[wb_adr_o[9:0]] <= 1'b1;
        end
    end

    // ---------------- monitor (samples on falling edge) ----------------
    typedef struct {
        int          cyc;
        logic        we;
        logic [29:0] adr;
        logic [2:0]  cti;
        logic [31:0] dat;
        logic        err;
    } beat_t;

    beat_t beats[$];
    int    done_log[$], start_log[$], rise_log[$], fall_log[$], busy_rise_log[$];
    int    cycle_n = 0;
    logic  prev_cyc = 1'b0, prev_we = 1'b0, prev_busy = 1'b0;
    int    phase_mix = 0, sel_bad = 0, done_busy = 0;

    always @(negedge sys_clk) begin
        cycle_n   <= cycle_n + 1;
        prev_cyc  <= wb_cyc_o;
        prev_we   <= wb_we_o;
        prev_busy <= busy;
        if (start) start_log.push_back(cycle_n);
        if (wb_cyc_o === 1'b1 && (wb_ack_i || wb_err_i))
            beats.push_back('{cyc: cycle_n, we: wb_we_o, adr: wb_adr_o, cti: wb_cti_o,
                              dat: wb_dat_o, err: wb_err_i});
        if (done === 1'b1) done_log.push_back(cycle_n);
        if (done === 1'b1 && busy === 1'b1) done_busy <= done_busy + 1;
        if (busy === 1'b1 && prev_busy !== 1'b1) busy_rise_log.push_back(cycle_n);
        if (wb_cyc_o === 1'b1 && prev_cyc !== 1'b1) rise_log.push_back(cycle_n);
        if (wb_cyc_o === 1'b0 && prev_cyc === 1'b1) fall_log.push_back(cycle_n);
        if (wb_cyc_o === 1'b1 && prev_cyc === 1'b1 && wb_we_o !== prev_we) phase_mix <= phase_mix + 1;
        if (!sys_rst && (wb_sel_o !== (wb_cyc_o ? 4'hF : 4'h0) || wb_bte_o !== 2'b00 ||
                         wb_stb_o !== wb_cyc_o))
            sel_bad <= sel_bad + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic pulse_start(input logic [29:0] s, input logic [29:0] d, input int l);
        src_adr = s;
        dst_adr = d;
        len     = LEN_W'(l);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int dbase, input int budget, input string tag);
        int n = 0;
        while (done_log.size() == dbase && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(done_log.size() > dbase), 64'(1));
    endtask

    function automatic logic [2:0] exp_cti(input int i, input int n);
        if (n == 1) return 3'b000;
        if (i == n - 1) return 3'b111;
        return 3'b010;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, " ctrl"}, 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o,
                                 busy, done, error}), 64'(0));
        chk({tag, " adr_dat"}, 64'({wb_adr_o, wb_dat_o}), 64'(0));
        chk({tag, " words"}, 64'(words_done), 64'(0));
    endtask

    // Checks the beat sequence, phase count, done count and final count of a clean command.
    task automatic verify_cmd(input string tag, input logic [29:0] src, input logic [29:0] dst,
                              input int l, input int bbase, input int rbase, input int dbase,
                              input int sbase);
        int nchunks = (l + BURST - 1) / BURST;
        int off = 0;
        int idx = bbase;
        chk({tag, " beats"}, 64'(beats.size() - bbase), 64'(2 * l));
        chk({tag, " phases"}, 64'(rise_log.size() - rbase), 64'(2 * nchunks));
        chk({tag, " done_cnt"}, 64'(done_log.size() - dbase), 64'(1));
        chk({tag, " words_done"}, 64'(words_done), 64'(l));
        if (l > 0 && rise_log.size() > rbase && start_log.size() > sbase)
            chk({tag, " first_cyc"}, 64'(rise_log[rbase]), 64'(start_log[sbase] + 2));
        if (beats.size() - bbase == 2 * l) begin
            while (off < l) begin
                int n = (l - off > BURST) ? BURST : l - off;
                for (int i = 0; i < n; i++) begin
                    chk({tag, " rd_beat"}, 64'({beats[idx].we, beats[idx].cti, beats[idx].adr}),
                        64'({1'b0, exp_cti(i, n), 30'(src + 30'(off + i))}));
                    idx++;
                end
                for (int i = 0; i < n; i++) begin
                    chk({tag, " wr_beat"}, 64'({beats[idx].we, beats[idx].cti, beats[idx].adr}),
                        64'({1'b1, exp_cti(i, n), 30'(dst + 30'(off + i))}));
                    chk({tag, " wr_dat"}, 64'(beats[idx].dat), 64'(init_val(10'(src + 30'(off + i)))));
                    idx++;
                end
                off += n;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int bb, rb, db, sb, ub;

        // Reset state
        repeat (3) tick();
        chk_quiet("reset");
        sys_rst = 1'b0;
        tick();

        // T1: len=3, ack every cycle
        bb = beats.size(); rb = rise_log.size(); db = done_log.size(); sb = start_log.size();
        pulse_start(30'h100, 30'h200, 3);
        wait_done(db, 200, "t1 timeout");
        repeat (3) tick();
        verify_cmd("t1", 30'h100, 30'h200, 3, bb, rb, db, sb);
        for (int i = 0; i < 3; i++)
            chk("t1 mem", 64'(mem[10'(12'h200 + i)]), 64'(init_val(10'(12'h100 + i))));
        $display("t1 len=3 done, words_done=%0d", words_done);

        // T2: len=10, random ack, source wraps past the top of the address space
        ack_mode = 1;
        bb = beats.size(); rb = rise_log.size(); db = done_log.size(); sb = start_log.size();
        pulse_start(30'h3FFF_FFFC, 30'h300, 10);
        wait_done(db, 1000, "t2 timeout");
        repeat (3) tick();
        verify_cmd("t2", 30'h3FFF_FFFC, 30'h300, 10, bb, rb, db, sb);
        ack_mode = 0;
        $display("t2 len=10 done, words_done=%0d", words_done);

        // T3: len=1, classic beats, done two cycles after the write ack
        tick();
        bb = beats.size(); rb = rise_log.size(); db = done_log.size(); sb = start_log.size();
        pulse_start(30'h120, 30'h230, 1);
        wait_done(db, 200, "t3 timeout");
        repeat (3) tick();
        verify_cmd("t3", 30'h120, 30'h230, 1, bb, rb, db, sb);
        if (beats.size() > bb + 1 && done_log.size() > db)
            chk("t3 done_lat", 64'(done_log[db]), 64'(beats[bb + 1].cyc + 2));
        $display("t3 len=1 done, words_done=%0d", words_done);

        // T4: len=0, no bus activity, done one cycle after busy rises
        bb = beats.size(); rb = rise_log.size(); db = done_log.size(); sb = start_log.size();
        ub = busy_rise_log.size();
        pulse_start(30'h0, 30'h0, 0);
        wait_done(db, 50, "t4 timeout");
        repeat (3) tick();
        verify_cmd("t4", 30'h0, 30'h0, 0, bb, rb, db, sb);
        if (busy_rise_log.size() > ub && done_log.size() > db) begin
            chk("t4 busy_rise", 64'(busy_rise_log[ub]), 64'(start_log[sb] + 1));
            chk("t4 done_lat", 64'(done_log[db]), 64'(busy_rise_log[ub] + 1));
        end
        $display("t4 len=0 done, words_done=%0d", words_done);

        // T5: err (with ack) on the second write beat
        err_en = 1'b1; err_adr = 30'h241;
        bb = beats.size(); db = done_log.size();
        pulse_start(30'h140, 30'h240, 4);
        wait_done(db, 200, "t5 timeout");
        repeat (3) tick();
        chk("t5 beats", 64'(beats.size() - bb), 64'(6));
        chk("t5 error", 64'(error), 64'(1));
        chk("t5 words_done", 64'(words_done), 64'(1));
        chk("t5 done_cnt", 64'(done_log.size() - db), 64'(1));
        if (beats.size() == bb + 6 && fall_log.size() > 0 && done_log.size() > db) begin
            chk("t5 err_beat", 64'({beats[bb + 5].err, beats[bb + 5].we, beats[bb + 5].adr}),
                64'({2'b11, 30'h241}));
            chk("t5 cyc_drop", 64'(fall_log[fall_log.size() - 1]), 64'(beats[bb + 5].cyc + 1));
            chk("t5 done_at", 64'(done_log[db]), 64'(beats[bb + 5].cyc + 1));
        end
        err_en = 1'b0;
        db = done_log.size();
        pulse_start(30'h150, 30'h250, 1);
        chk("t5 error_clear", 64'({error, busy}), 64'(2'b01));
        wait_done(db, 200, "t5b timeout");
        repeat (3) tick();
        chk("t5b words_done", 64'(words_done), 64'(1));
        $display("t5 error path done, error=%0b", error);

        // T6: reset in the middle of a stalled read burst
        ack_mode = 2;
        tick();
        bb = beats.size();
        pulse_start(30'h160, 30'h260, 4);
        for (int n = 0; n < 20 && wb_cyc_o !== 1'b1; n++) tick();
        repeat (2) tick();
        chk("t6 stalled", 64'({wb_cyc_o, 32'(beats.size() - bb)}), 64'({1'b1, 32'd0}));
        sys_rst = 1'b1;
        tick();
        chk_quiet("t6 mid_rst");
        sys_rst = 1'b0;
        ack_mode = 0;
        tick();
        bb = beats.size(); rb = rise_log.size(); db = done_log.size(); sb = start_log.size();
        pulse_start(30'h180, 30'h280, 2);
        repeat (2) tick();
        pulse_start(30'h190, 30'h290, 5);
        wait_done(db, 200, "t6 timeout");
        repeat (3) tick();
        verify_cmd("t6", 30'h180, 30'h280, 2, bb, rb, db, sb);
        $display("t6 reset recovery done, words_done=%0d", words_done);

        // Whole-run bus hygiene
        chk("phase_we_mix", 64'(phase_mix), 64'(0));
        chk("sel_bte_stb", 64'(sel_bad), 64'(0));
        chk("done_with_busy", 64'(done_busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
